// File: rtl/imm_gen_pkg.sv
// rtl/imm_gen_pkg.sv - opcodes, format codes and per-lane result type for imm_gen_stage
package imm_gen_pkg;

   localparam int IMM_MAX = 64;

   localparam logic [6:0] OP_LOAD     = 7'b0000011;
   localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OP_IMM      = 7'b0010011;
   localparam logic [6:0] OP_IMM_32   = 7'b0011011;
   localparam logic [6:0] OP_JALR     = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
   localparam logic [6:0] OP_STORE    = 7'b0100011;
   localparam logic [6:0] OP_BRANCH   = 7'b1100011;
   localparam logic [6:0] OP_AUIPC    = 7'b0010111;
   localparam logic [6:0] OP_LUI      = 7'b0110111;
   localparam logic [6:0] OP_JAL      = 7'b1101111;
   localparam logic [6:0] OP_OP       = 7'b0110011;
   localparam logic [6:0] OP_OP_32    = 7'b0111011;

   typedef enum logic [2:0] {
      FMT_R       = 3'd0,
      FMT_I       = 3'd1,
      FMT_S       = 3'd2,
      FMT_B       = 3'd3,
      FMT_U       = 3'd4,
      FMT_J       = 3'd5,
      FMT_ILLEGAL = 3'd7
   } fmt_e;

   // imm is sized for the widest XLEN; narrower builds leave the top bits zero
   typedef struct packed {
      logic [IMM_MAX-1:0] imm;
      fmt_e               fmt;
      logic               illegal;
   } lane_res_t;

endpackage

// File: rtl/imm_gen_lane.sv
// rtl/imm_gen_lane.sv - combinational format decode and sign-extended immediate for one lane
module imm_gen_lane
   import imm_gen_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [31:0] i_instr,
   output lane_res_t   o_res
);

   always_comb begin
      o_res         = '0;
      o_res.fmt     = FMT_ILLEGAL;
      o_res.illegal = 1'b1;
      case (i_instr[6:0])
         OP_LOAD, OP_MISC_MEM, OP_IMM, OP_IMM_32, OP_JALR, OP_SYSTEM: begin
            o_res.fmt     = FMT_I;
            o_res.illegal = 1'b0;
            o_res.imm     = IMM_MAX'($signed(i_instr[31:20]));
         end
         OP_STORE: begin
            o_res.fmt     = FMT_S;
            o_res.illegal = 1'b0;
            o_res.imm     = IMM_MAX'($signed({i_instr[31:25], i_instr[11:7]}));
         end
         OP_BRANCH: begin
            o_res.fmt     = FMT_B;
            o_res.illegal = 1'b0;
            o_res.imm     = IMM_MAX'($signed({i_instr[31], i_instr[7], i_instr[30:25],
                                              i_instr[11:8], 1'b0}));
         end
         OP_AUIPC, OP_LUI: begin
            o_res.fmt     = FMT_U;
            o_res.illegal = 1'b0;
            o_res.imm     = IMM_MAX'($signed({i_instr[31:12], 12'b0}));
         end
         OP_JAL: begin
            o_res.fmt     = FMT_J;
            o_res.illegal = 1'b0;
            o_res.imm     = IMM_MAX'($signed({i_instr[31], i_instr[19:12], i_instr[20],
                                              i_instr[30:21], 1'b0}));
         end
         OP_OP, OP_OP_32: begin
            o_res.fmt     = FMT_R;
            o_res.illegal = 1'b0;
         end
         default: ;
      endcase
      if (XLEN == 32) o_res.imm[IMM_MAX-1:32] = '0;
   end

endmodule

// File: rtl/imm_gen_stage.sv
// rtl/imm_gen_stage.sv - registered multi-lane immediate generator with valid/ready handshake
// IMM_GEN_STAGE_SKID_EN selects a 2-entry skid buffer with a registered in_ready.
module imm_gen_stage
   import imm_gen_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int LANES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [LANES*32-1:0]   in_instr,
   input  logic [LANES-1:0]      in_lane_mask,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [LANES*XLEN-1:0] out_imm,
   output logic [LANES*3-1:0]    out_fmt,
   output logic [LANES-1:0]      out_lane_mask,
   output logic [LANES-1:0]      out_illegal
);

   generate
      if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
         $error("imm_gen_stage: XLEN must be 32 or 64");
      end
      if (LANES < 1 || LANES > 4) begin : g_bad_lanes
         $error("imm_gen_stage: LANES must be 1..4");
      end
   endgenerate

   lane_res_t [LANES-1:0] w_lane;
   lane_res_t [LANES-1:0] w_res;
   lane_res_t [LANES-1:0] r_main_res;
   logic [LANES-1:0]      r_main_mask;
   logic                  r_main_valid;
   logic                  w_in_fire;
   logic                  w_out_fire;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      imm_gen_lane #(.XLEN(XLEN)) u_lane (
         .i_instr (in_instr[32*i +: 32]),
         .o_res   (w_lane[i])
      );
      // an all-zero result is exactly imm=0, fmt=R, illegal=0
      assign w_res[i] = in_lane_mask[i] ? w_lane[i] : '0;

      assign out_imm[XLEN*i +: XLEN] = r_main_res[i].imm[XLEN-1:0];
      assign out_fmt[3*i +: 3]       = r_main_res[i].fmt;
      assign out_illegal[i]          = r_main_res[i].illegal;

      if (XLEN < IMM_MAX) begin : g_hi
         logic w_unused_hi;
         assign w_unused_hi = ^r_main_res[i].imm[IMM_MAX-1:XLEN];
      end
   end

   assign out_valid     = r_main_valid;
   assign out_lane_mask = r_main_mask;
   assign w_out_fire    = r_main_valid && out_ready;

`ifdef IMM_GEN_STAGE_SKID_EN
   lane_res_t [LANES-1:0] r_skid_res;
   logic [LANES-1:0]      r_skid_mask;
   logic                  r_skid_valid;
   logic                  r_in_ready;

   assign in_ready  = r_in_ready;
   assign w_in_fire = in_valid && r_in_ready;

   // r_in_ready tracks !r_skid_valid, so no input arrives while skid is occupied
   always_ff @(posedge clk) begin
      if (rst) begin
         r_main_valid <= 1'b0;
         r_main_res   <= '0;
         r_main_mask  <= '0;
         r_skid_valid <= 1'b0;
         r_skid_res   <= '0;
         r_skid_mask  <= '0;
         r_in_ready   <= 1'b0;
      end else begin
         r_in_ready <= 1'b1;
         if (r_skid_valid) begin
            if (w_out_fire) begin
               r_main_res   <= r_skid_res;
               r_main_mask  <= r_skid_mask;
               r_skid_valid <= 1'b0;
            end else begin
               r_in_ready <= 1'b0;
            end
         end else if (w_in_fire) begin
            if (!r_main_valid || w_out_fire) begin
               r_main_valid <= 1'b1;
               r_main_res   <= w_res;
               r_main_mask  <= in_lane_mask;
            end else begin
               r_skid_valid <= 1'b1;
               r_skid_res   <= w_res;
               r_skid_mask  <= in_lane_mask;
               r_in_ready   <= 1'b0;
            end
         end else if (w_out_fire) begin
            r_main_valid <= 1'b0;
         end
      end
   end
`else
   assign in_ready  = !rst && (!r_main_valid || out_ready);
   assign w_in_fire = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_main_valid <= 1'b0;
         r_main_res   <= '0;
         r_main_mask  <= '0;
      end else if (w_in_fire) begin
         r_main_valid <= 1'b1;
         r_main_res   <= w_res;
         r_main_mask  <= in_lane_mask;
      end else if (w_out_fire) begin
         r_main_valid <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_imm_gen_stage.sv
// tb/tb_imm_gen_stage.sv - directed and randomised self-checking bench for imm_gen_stage
module tb_imm_gen_stage;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         in_valid, in_ready, out_valid, out_ready;
   logic [127:0] in_instr;
   logic [3:0]   in_lane_mask;
   logic [255:0] out_imm;
   logic [11:0]  out_fmt;
   logic [3:0]   out_lane_mask, out_illegal;

   logic         d1_in_valid, d1_in_ready, d1_out_valid, d1_out_ready;
   logic [63:0]  d1_in_instr;
   logic [1:0]   d1_in_lane_mask;
   logic [63:0]  d1_out_imm;
   logic [5:0]   d1_out_fmt;
   logic [1:0]   d1_out_lane_mask, d1_out_illegal;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef IMM_GEN_STAGE_SKID_EN
   localparam int HELD_ACCEPTS = 2;
`else
   localparam int HELD_ACCEPTS = 1;
`endif

   logic [6:0] ops_tbl [16] = '{7'h03, 7'h0F, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h23, 7'h63,
                                7'h17, 7'h37, 7'h6F, 7'h33, 7'h3B, 7'h7F, 7'h10, 7'h00};

   typedef struct {
      logic [255:0] imm;
      logic [11:0]  fmt;
      logic [3:0]   ill;
      logic [3:0]   mask;
   } beat_t;

   imm_gen_stage #(.XLEN(64), .LANES(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .in_lane_mask(in_lane_mask), .out_valid(out_valid), .out_ready(out_ready),
      .out_imm(out_imm), .out_fmt(out_fmt), .out_lane_mask(out_lane_mask),
      .out_illegal(out_illegal)
   );

   imm_gen_stage #(.XLEN(32), .LANES(2)) dut32 (
      .clk(clk), .rst(rst), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
      .in_instr(d1_in_instr), .in_lane_mask(d1_in_lane_mask), .out_valid(d1_out_valid),
      .out_ready(d1_out_ready), .out_imm(d1_out_imm), .out_fmt(d1_out_fmt),
      .out_lane_mask(d1_out_lane_mask), .out_illegal(d1_out_illegal)
   );

   // arithmetic-shift formulation of the RV immediate rules
   function automatic void ref_lane(input logic [31:0] ins, input logic m,
                                    output logic [63:0] imm, output logic [2:0] fmt,
                                    output logic ill);
      int s;
      int v;
      s = ins;
      v = 0;
      fmt = 3'd0;
      ill = 1'b0;
      if (m) begin
         case (ins[6:0])
            7'h03, 7'h0F, 7'h13, 7'h1B, 7'h67, 7'h73: begin fmt = 3'd1; v = s >>> 20; end
            7'h23: begin fmt = 3'd2; v = ((s >>> 25) <<< 5) | int'(ins[11:7]); end
            7'h63: begin
               fmt = 3'd3;
               v = ((s >>> 31) <<< 12) | (int'(ins[7]) << 11) | (int'(ins[30:25]) << 5)
                   | (int'(ins[11:8]) << 1);
            end
            7'h17, 7'h37: begin fmt = 3'd4; v = s & 32'hFFFFF000; end
            7'h6F: begin
               fmt = 3'd5;
               v = ((s >>> 31) <<< 20) | (int'(ins[19:12]) << 12) | (int'(ins[20]) << 11)
                   | (int'(ins[30:21]) << 1);
            end
            7'h33, 7'h3B: fmt = 3'd0;
            default: begin fmt = 3'd7; ill = 1'b1; end
         endcase
      end
      imm = longint'(v);
   endfunction

   task automatic drive_beat(input logic [127:0] instr, input logic [3:0] mask);
      int budget = 0;
      @(negedge clk);
      in_valid = 1'b1; in_instr = instr; in_lane_mask = mask;
      #1;
      while (!in_ready && budget < 50) begin @(negedge clk); #1; budget++; end
      if (!in_ready) begin
         n_cmp++; n_bad++;
         $display("FAIL drive_timeout: in_ready=%b want 1", in_ready);
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0; in_lane_mask = '0;
      d1_in_valid = 1'b0; d1_out_ready = 1'b0; d1_in_instr = '0; d1_in_lane_mask = '0;
      @(posedge clk); @(negedge clk); #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL post_rst_valid: got %b want 0", out_valid); end
      n_cmp++; if (out_imm !== '0) begin n_bad++; $display("FAIL post_rst_imm: got %h want 0", out_imm); end
      n_cmp++; if ({out_fmt, out_lane_mask, out_illegal} !== 20'h0) begin
         n_bad++; $display("FAIL post_rst_side: got fmt %h mask %h ill %h want 0", out_fmt, out_lane_mask, out_illegal);
      end
   endtask

   task automatic test_i_b();
      out_ready = 1'b1;
      drive_beat({32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFE208CE3, 32'hFFF00093}, 4'b0011);
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL ib_valid: got %b want 1", out_valid); end
      n_cmp++; if (out_imm !== {128'h0, 64'hFFFFFFFFFFFFFFF8, 64'hFFFFFFFFFFFFFFFF}) begin
         n_bad++; $display("FAIL ib_imm: got %h", out_imm);
      end
      n_cmp++; if (out_fmt !== {3'd0, 3'd0, 3'd3, 3'd1}) begin n_bad++; $display("FAIL ib_fmt: got %h want 019", out_fmt); end
      n_cmp++; if ({out_illegal, out_lane_mask} !== 8'h03) begin
         n_bad++; $display("FAIL ib_ill_mask: got %h %h want 0 3", out_illegal, out_lane_mask);
      end
   endtask

   task automatic test_u_j();
      int budget = 0;
      out_ready = 1'b1;
      drive_beat({32'h12345017, 32'h7FF00093, 32'hFFFFF0EF, 32'hFFFFF0B7}, 4'hF);
      n_cmp++; if (out_imm !== {64'h12345000, 64'h7FF, 64'hFFFFFFFFFFFFFFFE, 64'hFFFFFFFFFFFFF000}) begin
         n_bad++; $display("FAIL uj64_imm: got %h", out_imm);
      end
      n_cmp++; if (out_fmt !== {3'd4, 3'd1, 3'd5, 3'd4}) begin n_bad++; $display("FAIL uj64_fmt: got %h", out_fmt); end

      @(negedge clk);
      d1_in_valid = 1'b1; d1_in_instr = {32'hFFFFF0EF, 32'hFFFFF0B7}; d1_in_lane_mask = 2'b11;
      d1_out_ready = 1'b1;
      #1;
      while (!d1_in_ready && budget < 50) begin @(negedge clk); #1; budget++; end
      if (!d1_in_ready) begin n_cmp++; n_bad++; $display("FAIL uj32_timeout: in_ready=%b want 1", d1_in_ready); end
      @(posedge clk); @(negedge clk);
      d1_in_valid = 1'b0;
      #1;
      n_cmp++; if (d1_out_valid !== 1'b1) begin n_bad++; $display("FAIL uj32_valid: got %b want 1", d1_out_valid); end
      n_cmp++; if (d1_out_imm !== {32'hFFFFFFFE, 32'hFFFFF000}) begin n_bad++; $display("FAIL uj32_imm: got %h", d1_out_imm); end
      n_cmp++; if ({d1_out_fmt, d1_out_illegal, d1_out_lane_mask} !== {3'd5, 3'd4, 2'b00, 2'b11}) begin
         n_bad++; $display("FAIL uj32_side: got %h %h %h", d1_out_fmt, d1_out_illegal, d1_out_lane_mask);
      end
   endtask

   task automatic test_s_illegal();
      out_ready = 1'b1;
      drive_beat({32'h0000007F, 32'h00000033, 32'h00000000, 32'h00412223}, 4'hF);
      n_cmp++; if (out_imm !== {192'h0, 64'd4}) begin n_bad++; $display("FAIL s_imm: got %h", out_imm); end
      n_cmp++; if (out_fmt !== {3'd7, 3'd0, 3'd7, 3'd2}) begin n_bad++; $display("FAIL s_fmt: got %h", out_fmt); end
      n_cmp++; if (out_illegal !== 4'b1010) begin n_bad++; $display("FAIL s_illegal: got %b want 1010", out_illegal); end
      drive_beat({32'h0000007F, 32'h00000033, 32'h00000000, 32'h00412223}, 4'b0001);
      n_cmp++; if (out_imm !== {192'h0, 64'd4}) begin n_bad++; $display("FAIL masked_imm: got %h", out_imm); end
      n_cmp++; if (out_fmt !== {3'd0, 3'd0, 3'd0, 3'd2}) begin n_bad++; $display("FAIL masked_fmt: got %h", out_fmt); end
      n_cmp++; if ({out_illegal, out_lane_mask} !== 8'h01) begin
         n_bad++; $display("FAIL masked_ill: got %b %b want 0000 0001", out_illegal, out_lane_mask);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] beats [3] = '{32'h00100093, 32'h00200093, 32'h00300093};
      logic [63:0] got [8];
      int          cyc_at [8];
      int          idx = 0;
      int          n = 0;
      for (int k = 0; k < 8; k++) begin got[k] = '0; cyc_at[k] = 0; end
      out_ready = 1'b1; in_valid = 1'b0;
      repeat (2) @(posedge clk);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         out_ready = 1'b0;
         in_valid = (idx < 3);
         in_instr = {96'h0, beats[(idx < 3) ? idx : 0]}; in_lane_mask = 4'b0001;
         #1;
         if (in_valid && in_ready) idx++;
      end
      n_cmp++; if (idx != HELD_ACCEPTS) begin n_bad++; $display("FAIL bp_accepts: got %0d want %0d", idx, HELD_ACCEPTS); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
      n_cmp++; if (out_valid !== 1'b1 || out_imm[63:0] !== 64'd1) begin
         n_bad++; $display("FAIL bp_head: got valid %b imm %h want 1 1", out_valid, out_imm[63:0]);
      end
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         out_ready = 1'b1;
         in_valid = (idx < 3);
         in_instr = {96'h0, beats[(idx < 3) ? idx : 0]};
         #1;
         if (out_valid) begin
            if (n < 8) begin got[n] = out_imm[63:0]; cyc_at[n] = c; end
            n++;
         end
         if (in_valid && in_ready) idx++;
      end
      in_valid = 1'b0;
      n_cmp++; if (n != 3) begin n_bad++; $display("FAIL bp_count: got %0d beats want 3", n); end
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if (got[k] !== 64'(k + 1)) begin n_bad++; $display("FAIL bp_order%0d: got %h want %h", k, got[k], 64'(k + 1)); end
      end
      n_cmp++; if (cyc_at[2] - cyc_at[0] != 2) begin
         n_bad++; $display("FAIL bp_consecutive: got span %0d want 2", cyc_at[2] - cyc_at[0]);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] beats [2] = '{32'h00A00093, 32'h00B00093};
      int idx = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         out_ready = 1'b0;
         in_valid = (idx < 2);
         in_instr = {96'h0, beats[(idx < 2) ? idx : 0]}; in_lane_mask = 4'b0001;
         #1;
         if (in_valid && in_ready) idx++;
      end
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
      n_cmp++; if (out_imm !== '0 || {out_fmt, out_illegal, out_lane_mask} !== 20'h0) begin
         n_bad++; $display("FAIL midrst_outs: got imm %h fmt %h ill %h mask %h want 0", out_imm, out_fmt, out_illegal, out_lane_mask);
      end
      out_ready = 1'b1;
      drive_beat({96'h0, 32'h00500093}, 4'b0001);
      n_cmp++; if (out_valid !== 1'b1 || out_imm[63:0] !== 64'd5 || out_lane_mask !== 4'b0001) begin
         n_bad++; $display("FAIL midrst_next: got valid %b imm %h mask %b want 1 5 0001", out_valid, out_imm[63:0], out_lane_mask);
      end
      @(negedge clk); #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_stale: got valid %b imm %h want 0", out_valid, out_imm[63:0]); end
   endtask

   task automatic test_random();
      beat_t        exp_q [$];
      beat_t        e;
      logic [275:0] snap;
      logic [63:0]  li;
      logic [2:0]   lf;
      logic         ll;
      logic [31:0]  r;
      bit           hold = 0;
      bit           stalled = 0;
      int           sent = 0;
      int           rcvd = 0;
      int           cyc = 0;
      snap = '0;
      while (rcvd < 1000 && cyc < 30000) begin
         @(negedge clk);
         if (stalled) begin
            n_cmp++;
            if (out_valid !== 1'b1 || {out_imm, out_fmt, out_illegal, out_lane_mask} !== snap) begin
               n_bad++; $display("FAIL stall_stable: cycle %0d valid %b outputs changed while held", cyc, out_valid);
            end
         end
         if (!hold) begin
            if (sent < 1000 && $urandom_range(3) != 0) begin
               for (int k = 0; k < 4; k++) begin
                  r = $urandom();
                  r[6:0] = ops_tbl[$urandom_range(15)];
                  in_instr[32*k +: 32] = r;
               end
               in_lane_mask = 4'($urandom_range(15));
               in_valid = 1'b1;
               hold = 1;
            end else begin
               in_valid = 1'b0;
            end
         end
         out_ready = ($urandom_range(2) != 0);
         #1;
         if (out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++; $display("FAIL rand_extra: unexpected beat imm %h", out_imm[63:0]);
            end else begin
               e = exp_q.pop_front();
               if ({out_imm, out_fmt, out_illegal, out_lane_mask} !== {e.imm, e.fmt, e.ill, e.mask}) begin
                  n_bad++;
                  $display("FAIL rand_beat%0d: got %h %h %h %h want %h %h %h %h", rcvd, out_imm, out_fmt,
                           out_illegal, out_lane_mask, e.imm, e.fmt, e.ill, e.mask);
               end
            end
            rcvd++;
         end
         if (in_valid && in_ready) begin
            for (int k = 0; k < 4; k++) begin
               ref_lane(in_instr[32*k +: 32], in_lane_mask[k], li, lf, ll);
               e.imm[64*k +: 64] = li; e.fmt[3*k +: 3] = lf; e.ill[k] = ll;
            end
            e.mask = in_lane_mask;
            exp_q.push_back(e);
            sent++;
            hold = 0;
         end
         stalled = out_valid && !out_ready;
         if (stalled) snap = {out_imm, out_fmt, out_illegal, out_lane_mask};
         cyc++;
      end
      in_valid = 1'b0;
      n_cmp++; if (rcvd != 1000) begin n_bad++; $display("FAIL rand_count: got %0d beats want 1000 in %0d cycles", rcvd, cyc); end
   endtask

   initial begin
      test_reset();
      test_i_b();
      test_u_j();
      test_s_illegal();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/imm_gen_stage.md
# imm_gen_stage

Registered, parametrised multi-lane immediate generator for the decode stage. It accepts a bundle of LANES instructions per beat over a valid/ready handshake and classifies each lane's format. It emits the XLEN-wide sign-extended immediate per lane, one cycle after acceptance. This is the successor to the fixed two-lane, 64-bit, purely combinational immediate generator: it adds lane count and XLEN parameters, per-lane format/illegal outputs, backpressure buffering and RV64-correct U-type sign extension.

## Interface
Parameters:
- XLEN, 64, immediate width; legal values 32 or 64 (elaboration error otherwise)
- LANES, 2, instructions per beat; legal range 1..4

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat present
- in_ready  out  1  block can accept a beat this cycle
- in_instr  in  LANES*32  lane i at bits [32i+31:32i]
- in_lane_mask  in  LANES  lane i carries a real instruction
- out_valid  out  1  output beat present
- out_ready  in  1  consumer accepts beat this cycle
- out_imm  out  LANES*XLEN  lane i at [XLEN*i+XLEN-1:XLEN*i]
- out_fmt  out  LANES*3  per-lane format code (see package)
- out_lane_mask  out  LANES  registered copy of in_lane_mask
- out_illegal  out  LANES  per-lane unrecognised opcode

## Operation
- Transfer on a side happens when valid && ready are both high on a rising edge.
- Opcode[6:0] → format:
  - I: 0000011, 0001111, 0010011, 0011011, 1100111, 1110011
  - S: 0100011
  - B: 1100011
  - U: 0010111, 0110111
  - J: 1101111
  - R: 0110011, 0111011
- Immediates, all sign-extended from instr[31] to XLEN:
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U: {instr[31:12], 12'b0}; XLEN=64 fills bits [63:32] with instr[31]
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - R: imm 0
- Any other opcode, including bits[1:0] != 2'b11: fmt=ILLEGAL, imm=0, illegal=1.
- Masked-off lane (mask bit 0): imm=0, fmt=R, illegal=0 regardless of instr contents.
- Lanes are independent; no cross-lane interaction.
- Beats leave in acceptance order; no beat is dropped or duplicated.

## Timing
- Latency: a beat accepted at edge N is presented on out_* with out_valid=1 after edge N.
- Reset, while rst is high and on the first cycle after:
  - out_valid=0, in_ready=0 while rst high
  - out_imm=0, out_fmt=0, out_lane_mask=0, out_illegal=0
  - All buffered beats are discarded.
- Reset mid-operation discards main and skid contents; out_valid is 0 the cycle after the reset edge.
- Skid mode (macro defined):
  - Two entries: main and skid; in_ready = !skid_valid, registered, with no combinational path from out_ready.
  - Input accepted while main is full and out_ready=0 goes to skid.
  - When main drains, skid moves to main on the same edge.
  - Simultaneous input accept and output accept with skid empty: main is overwritten with the new beat.
  - Full throughput: 1 beat/cycle sustained when out_ready=1.
- out_* are held stable while out_valid=1 and out_ready=0.

## Configuration
- IMM_GEN_STAGE_SKID_EN defined: 2-entry skid buffer as above; in_ready is a pure register output.
- Not defined: single pipeline register.
  - in_ready = !out_valid || out_ready, which is a combinational path from out_ready to in_ready.
  - Still 1-cycle latency and full throughput when out_ready=1.
  - No skid storage.

## Structure
- Package imm_gen_pkg holds:
  - opcode localparams
  - 3-bit fmt_e: R=0, I=1, S=2, B=3, U=4, J=5, ILLEGAL=7
  - a packed per-lane result struct {imm, fmt, illegal}, parameterised by XLEN via a function or maximum width
- Sub-module imm_gen_lane: combinational 32-bit instr + XLEN → {imm, fmt, illegal}, instantiated LANES times by generate.
- Top level: handshake control, main/skid registers, mask gating.

## Test plan
- ADDI -1 (0xFFF00093) lane0, BEQ -8 (0xFE208CE3) lane1, XLEN=64 → out_imm lane0 0xFFFFFFFFFFFFFFFF fmt I; lane1 0xFFFFFFFFFFFFFFF8 fmt B; out_valid one cycle after accept.
- LUI 0xFFFFF (0xFFFFF0B7) and JAL -2 (0xFFFFF0EF), XLEN=64 → 0xFFFFFFFFFFFFF000 fmt U, 0xFFFFFFFFFFFFFFFE fmt J; repeat with XLEN=32 → 0xFFFFF000, 0xFFFFFFFE.
- SW +4 (0x00412223) lane0, 0x00000000 lane1 → lane0 imm 4 fmt S; lane1 illegal=1 fmt 7 imm 0. Same beat with mask=2'b01 → lane1 illegal=0 fmt 0.
- Skid mode: out_ready=0, send beats A, B, C back-to-back → after B, in_ready=0 and C is held. Raise out_ready → A, B, C emerge on consecutive cycles with no loss or duplication.
- Random valid/ready toggling for 1000 beats, LANES=4 → scoreboard matches a reference model; out_* stable during stall.
- Both entries full, rst pulsed for 1 cycle → out_valid=0 the next cycle and all outputs 0; the next accepted beat is emitted correctly with no stale data.
